loop_nest_ctrl_v2: RTL and testbench

Programmable nested-loop iteration generator for the SIMD controller. It holds per-group loop bounds, strides and base address. It walks the loop nest under a valid/ready handshake, emitting the iteration vector and a linear address. Each group keeps its own saved context, so a group switch preempts the running group and resumes it later exactly where it stopped. It is the successor to the stall-driven group loop FSM: explicit loop addressing, strides, address generation and backpressure.

---
 rtl/loop_nest_ctrl_v2_pkg.sv | 22 ++
 rtl/loop_nest_ctrl_v2_step.sv | 45 ++++
 rtl/loop_nest_ctrl_v2.sv | 171 +++++++++++++++++
 tb/tb_loop_nest_ctrl_v2.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_nest_ctrl_v2_pkg.sv
// Shared types and default widths for the nested-loop iteration generator.
package loop_nest_ctrl_v2_pkg;

  localparam int unsigned DEF_NUM_LOOPS  = 8;
  localparam int unsigned DEF_NUM_GROUPS = 4;
  localparam int unsigned DEF_ITER_W     = 16;
  localparam int unsigned DEF_ADDR_W     = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GS_FRESH    = 2'd0,
    GS_ACTIVE   = 2'd1,
    GS_FINISHED = 2'd2
  } gstat_t;

endpackage

// File: rtl/loop_nest_ctrl_v2_step.sv
// Combinational wrap chain, next-iterator/next-offset and address sum for one live context.
module loop_nest_step
  import loop_nest_ctrl_v2_pkg::*;
#(
  parameter int unsigned NUM_LOOPS = DEF_NUM_LOOPS,
  parameter int unsigned ITER_W    = DEF_ITER_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic [NUM_LOOPS*ITER_W-1:0] iters,
  input  logic [NUM_LOOPS*ITER_W-1:0] max_iters,
  input  logic [NUM_LOOPS*ADDR_W-1:0] offs,
  input  logic [NUM_LOOPS*ADDR_W-1:0] strides,
  input  logic [ADDR_W-1:0]           base,
  output logic [NUM_LOOPS-1:0]        wrap,
  output logic [NUM_LOOPS*ITER_W-1:0] next_iters,
  output logic [NUM_LOOPS*ADDR_W-1:0] next_offs,
  output logic [ADDR_W-1:0]           addr
);

  logic [NUM_LOOPS:0] chain;

  // Walk from the innermost loop outward so chain[i+1] is settled before chain[i].
  always_comb begin
    chain      = '0;
    chain[NUM_LOOPS] = 1'b1;
    next_iters = iters;
    next_offs  = offs;
    addr       = base;
    for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
      int unsigned i;
      i = NUM_LOOPS - 1 - k;
      chain[i] = (iters[i*ITER_W +: ITER_W] == max_iters[i*ITER_W +: ITER_W]) && chain[i+1];
      if (chain[i]) begin
        next_iters[i*ITER_W +: ITER_W] = '0;
        next_offs[i*ADDR_W +: ADDR_W]  = '0;
      end else if (chain[i+1]) begin
        next_iters[i*ITER_W +: ITER_W] = iters[i*ITER_W +: ITER_W] + ITER_W'(1);
        next_offs[i*ADDR_W +: ADDR_W]  = offs[i*ADDR_W +: ADDR_W] + strides[i*ADDR_W +: ADDR_W];
      end
      addr = addr + offs[i*ADDR_W +: ADDR_W];
    end
    wrap = chain[NUM_LOOPS-1:0];
  end

endmodule

// File: rtl/loop_nest_ctrl_v2.sv
// Programmable nested-loop iteration generator with per-group config banks and saved contexts.
module loop_nest_ctrl_v2
  import loop_nest_ctrl_v2_pkg::*;
#(
  parameter int unsigned NUM_LOOPS  = DEF_NUM_LOOPS,
  parameter int unsigned NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int unsigned ITER_W     = DEF_ITER_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LOOP_ID_W  = $clog2(NUM_LOOPS),
  parameter int unsigned GROUP_ID_W = $clog2(NUM_GROUPS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_v,
  input  logic                        cfg_base_v,
  input  logic [GROUP_ID_W-1:0]       cfg_group,
  input  logic [LOOP_ID_W-1:0]        cfg_loop,
  input  logic [ITER_W-1:0]           cfg_max,
  input  logic [ADDR_W-1:0]           cfg_stride,
  input  logic [ADDR_W-1:0]           cfg_base,
  input  logic                        start,
  input  logic [GROUP_ID_W-1:0]       group_sel,
  output logic                        busy,
  output logic                        done,
  output logic                        out_v,
  input  logic                        out_ready,
  output logic [NUM_LOOPS*ITER_W-1:0] out_iters,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [GROUP_ID_W-1:0]       out_group,
  output logic                        out_last,
  output logic [NUM_LOOPS-1:0]        wrap
);

  state_t                      state_q;
  logic [GROUP_ID_W-1:0]       active_q;
  gstat_t                      status_q    [NUM_GROUPS];

  logic [ITER_W-1:0]           bank_max    [NUM_GROUPS][NUM_LOOPS];
  logic [ADDR_W-1:0]           bank_stride [NUM_GROUPS][NUM_LOOPS];
  logic [ADDR_W-1:0]           bank_base   [NUM_GROUPS];
  logic [ITER_W-1:0]           ctx_iters   [NUM_GROUPS][NUM_LOOPS];
  logic [ADDR_W-1:0]           ctx_offs    [NUM_GROUPS][NUM_LOOPS];

  logic [NUM_LOOPS*ITER_W-1:0] iters_q, max_q, next_iters, rst_iters;
  logic [NUM_LOOPS*ADDR_W-1:0] offs_q, stride_q, next_offs, rst_offs;
  logic [ADDR_W-1:0]           base_q, addr_c;
  logic [NUM_LOOPS-1:0]        wrap_c;
  logic                        accept, adv, same_grp;

  loop_nest_step #(
    .NUM_LOOPS (NUM_LOOPS),
    .ITER_W    (ITER_W),
    .ADDR_W    (ADDR_W)
  ) u_step (
    .iters      (iters_q),
    .max_iters  (max_q),
    .offs       (offs_q),
    .strides    (stride_q),
    .base       (base_q),
    .wrap       (wrap_c),
    .next_iters (next_iters),
    .next_offs  (next_offs),
    .addr       (addr_c)
  );

  assign out_v     = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_iters = iters_q;
  assign out_addr  = addr_c;
  assign out_group = active_q;
  assign out_last  = out_v && wrap_c[0];
  assign wrap      = {NUM_LOOPS{out_v}} & wrap_c;
  assign accept    = out_v && out_ready;
  assign adv       = accept && !wrap_c[0];
  assign same_grp  = (group_sel == active_q);

  // A switch back to the group being saved must keep the live values, not the stale context slot.
  always_comb begin
    rst_iters = '0;
    rst_offs  = '0;
    for (int unsigned l = 0; l < NUM_LOOPS; l++) begin
      rst_iters[l*ITER_W +: ITER_W] = same_grp ? iters_q[l*ITER_W +: ITER_W] : ctx_iters[group_sel][l];
      rst_offs[l*ADDR_W +: ADDR_W]  = same_grp ? offs_q[l*ADDR_W +: ADDR_W]  : ctx_offs[group_sel][l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      iters_q  <= '0;
      offs_q   <= '0;
      max_q    <= '0;
      stride_q <= '0;
      base_q   <= '0;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        status_q[g]  <= GS_FRESH;
        bank_base[g] <= '0;
        for (int unsigned l = 0; l < NUM_LOOPS; l++) begin
          bank_max[g][l]    <= '0;
          bank_stride[g][l] <= '0;
          ctx_iters[g][l]   <= '0;
          ctx_offs[g][l]    <= '0;
        end
      end
    end else begin
      if (cfg_v) begin
        bank_max[cfg_group][cfg_loop]    <= cfg_max;
        bank_stride[cfg_group][cfg_loop] <= cfg_stride;
      end
      if (cfg_base_v) begin
        bank_base[cfg_group] <= cfg_base;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int unsigned l = 0; l < NUM_LOOPS; l++) begin
              max_q[l*ITER_W +: ITER_W]    <= bank_max[group_sel][l];
              stride_q[l*ADDR_W +: ADDR_W] <= bank_stride[group_sel][l];
            end
            base_q              <= bank_base[group_sel];
            iters_q             <= '0;
            offs_q              <= '0;
            status_q[group_sel] <= GS_ACTIVE;
            active_q            <= group_sel;
            state_q             <= ST_RUN;
          end else if (!same_grp && status_q[group_sel] == GS_ACTIVE) begin
            state_q <= ST_SWITCH;
          end
        end

        ST_RUN: begin
          if (adv) begin
            iters_q <= next_iters;
            offs_q  <= next_offs;
          end
          if (accept && wrap_c[0]) begin
            state_q <= ST_DONE;
          end else if (!same_grp) begin
            state_q <= ST_SWITCH;
          end
        end

        ST_SWITCH: begin
          for (int unsigned l = 0; l < NUM_LOOPS; l++) begin
            ctx_iters[active_q][l]       <= iters_q[l*ITER_W +: ITER_W];
            ctx_offs[active_q][l]        <= offs_q[l*ADDR_W +: ADDR_W];
            max_q[l*ITER_W +: ITER_W]    <= bank_max[group_sel][l];
            stride_q[l*ADDR_W +: ADDR_W] <= bank_stride[group_sel][l];
          end
          iters_q  <= rst_iters;
          offs_q   <= rst_offs;
          base_q   <= bank_base[group_sel];
          active_q <= group_sel;
          state_q  <= (status_q[group_sel] == GS_ACTIVE) ? ST_RUN : ST_IDLE;
        end

        ST_DONE: begin
          status_q[active_q] <= GS_FINISHED;
          iters_q            <= '0;
          state_q            <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_ctrl_v2.sv
// Directed table-driven bench for loop_nest_ctrl_v2 with two loops per nest.
module tb_loop_nest_ctrl_v2;

  localparam int unsigned NL = 2;
  localparam int unsigned NG = 4;
  localparam int unsigned IW = 16;
  localparam int unsigned AW = 24;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_v, cfg_base_v;
  logic [1:0]     cfg_group;
  logic [0:0]     cfg_loop;
  logic [IW-1:0]  cfg_max;
  logic [AW-1:0]  cfg_stride, cfg_base;
  logic           start;
  logic [1:0]     group_sel;
  logic           busy, done, out_v, out_ready, out_last;
  logic [NL*IW-1:0] out_iters;
  logic [AW-1:0]  out_addr;
  logic [1:0]     out_group;
  logic [NL-1:0]  wrap;

  int checks = 0;
  int errors = 0;
  int accepted;
  int nb;
  logic [AW-1:0] last_a;

  typedef struct {
    logic          ready;
    logic          exp_v;
    logic [AW-1:0] exp_addr;
    logic [IW-1:0] exp_i0;
    logic [IW-1:0] exp_i1;
    logic          exp_last;
    logic          exp_done;
    logic          exp_busy;
  } vec_t;

  vec_t walk_vecs [8];
  vec_t bp_vecs   [14];

  loop_nest_ctrl_v2 #(
    .NUM_LOOPS  (NL),
    .NUM_GROUPS (NG),
    .ITER_W     (IW),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_v      (cfg_v),
    .cfg_base_v (cfg_base_v),
    .cfg_group  (cfg_group),
    .cfg_loop   (cfg_loop),
    .cfg_max    (cfg_max),
    .cfg_stride (cfg_stride),
    .cfg_base   (cfg_base),
    .start      (start),
    .group_sel  (group_sel),
    .busy       (busy),
    .done       (done),
    .out_v      (out_v),
    .out_ready  (out_ready),
    .out_iters  (out_iters),
    .out_addr   (out_addr),
    .out_group  (out_group),
    .out_last   (out_last),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input bit r, input bit v, input int unsigned a,
                              input int unsigned i0, input int unsigned i1,
                              input bit l, input bit d, input bit b);
    vec_t x;
    x.ready    = r;
    x.exp_v    = v;
    x.exp_addr = AW'(a);
    x.exp_i0   = IW'(i0);
    x.exp_i1   = IW'(i1);
    x.exp_last = l;
    x.exp_done = d;
    x.exp_busy = b;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cfg_loop_w(input int g, input int l, input int unsigned mx, input int unsigned st);
    cfg_v = 1'b1; cfg_group = 2'(g); cfg_loop = 1'(l); cfg_max = IW'(mx); cfg_stride = AW'(st);
    tick();
    cfg_v = 1'b0;
  endtask

  task automatic cfg_base_w(input int g, input int unsigned b);
    cfg_base_v = 1'b1; cfg_group = 2'(g); cfg_base = AW'(b);
    tick();
    cfg_base_v = 1'b0;
  endtask

  task automatic do_start(input int g);
    group_sel = 2'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    out_ready = v.ready;
    check($sformatf("%s[%0d].out_v", tag, idx), 64'(out_v), 64'(v.exp_v));
    if (v.exp_v) begin
      check($sformatf("%s[%0d].addr", tag, idx), 64'(out_addr), 64'(v.exp_addr));
      check($sformatf("%s[%0d].iter0", tag, idx), 64'(out_iters[IW-1:0]), 64'(v.exp_i0));
      check($sformatf("%s[%0d].iter1", tag, idx), 64'(out_iters[2*IW-1:IW]), 64'(v.exp_i1));
      check($sformatf("%s[%0d].last", tag, idx), 64'(out_last), 64'(v.exp_last));
    end
    check($sformatf("%s[%0d].done", tag, idx), 64'(done), 64'(v.exp_done));
    check($sformatf("%s[%0d].busy", tag, idx), 64'(busy), 64'(v.exp_busy));
    if (out_v && out_ready) accepted++;
    tick();
  endtask

  // Runs the current walk to completion with out_ready high; optional config write at cycle cfg_at.
  task automatic collect(input int cfg_at, output int n, output logic [AW-1:0] la);
    bit seen;
    seen = 1'b0;
    n = 0;
    la = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cfg_v = (c == cfg_at); cfg_group = 2'd0; cfg_loop = 1'b1; cfg_max = 16'd5; cfg_stride = 24'd1;
      if (out_v) begin
        n++;
        la = out_addr;
      end
      if (done) begin
        seen = 1'b1;
        cfg_v = 1'b0;
        tick();
        break;
      end
      tick();
    end
    cfg_v = 1'b0;
    check("collect_done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    walk_vecs[0] = mk(1, 1, 100, 0, 0, 0, 0, 1);
    walk_vecs[1] = mk(1, 1, 101, 0, 1, 0, 0, 1);
    walk_vecs[2] = mk(1, 1, 102, 0, 2, 0, 0, 1);
    walk_vecs[3] = mk(1, 1, 110, 1, 0, 0, 0, 1);
    walk_vecs[4] = mk(1, 1, 111, 1, 1, 0, 0, 1);
    walk_vecs[5] = mk(1, 1, 112, 1, 2, 1, 0, 1);
    walk_vecs[6] = mk(1, 0, 0, 0, 0, 0, 1, 1);
    walk_vecs[7] = mk(1, 0, 0, 0, 0, 0, 0, 0);

    bp_vecs[0]  = mk(1, 1, 100, 0, 0, 0, 0, 1);
    bp_vecs[1]  = mk(0, 1, 101, 0, 1, 0, 0, 1);
    bp_vecs[2]  = mk(0, 1, 101, 0, 1, 0, 0, 1);
    bp_vecs[3]  = mk(1, 1, 101, 0, 1, 0, 0, 1);
    bp_vecs[4]  = mk(0, 1, 102, 0, 2, 0, 0, 1);
    bp_vecs[5]  = mk(0, 1, 102, 0, 2, 0, 0, 1);
    bp_vecs[6]  = mk(1, 1, 102, 0, 2, 0, 0, 1);
    bp_vecs[7]  = mk(1, 1, 110, 1, 0, 0, 0, 1);
    bp_vecs[8]  = mk(0, 1, 111, 1, 1, 0, 0, 1);
    bp_vecs[9]  = mk(1, 1, 111, 1, 1, 0, 0, 1);
    bp_vecs[10] = mk(0, 1, 112, 1, 2, 1, 0, 1);
    bp_vecs[11] = mk(1, 1, 112, 1, 2, 1, 0, 1);
    bp_vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    bp_vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1; cfg_v = 1'b0; cfg_base_v = 1'b0; cfg_group = '0; cfg_loop = '0;
    cfg_max = '0; cfg_stride = '0; cfg_base = '0; start = 1'b0; group_sel = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst.out_v", 64'(out_v), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.addr", 64'(out_addr), 64'd0);
    check("rst.iters", 64'(out_iters), 64'd0);
    check("rst.last", 64'(out_last), 64'd0);
    check("rst.wrap", 64'(wrap), 64'd0);
    check("rst.group", 64'(out_group), 64'd0);
    reset = 1'b0;
    tick();

    // Basic walk
    cfg_loop_w(0, 0, 1, 10);
    cfg_loop_w(0, 1, 2, 1);
    cfg_base_w(0, 100);
    do_start(0);
    accepted = 0;
    for (int i = 0; i < 8; i++) apply_vec("walk", i, walk_vecs[i]);
    check("walk.accepted", 64'(accepted), 64'd6);

    // Backpressure
    do_start(0);
    accepted = 0;
    for (int i = 0; i < 14; i++) apply_vec("bp", i, bp_vecs[i]);
    check("bp.accepted", 64'(accepted), 64'd6);

    // Degenerate: all bounds zero
    cfg_base_w(3, 7);
    do_start(3);
    check("degen.out_v", 64'(out_v), 64'd1);
    check("degen.last", 64'(out_last), 64'd1);
    check("degen.addr", 64'(out_addr), 64'd7);
    check("degen.wrap", 64'(wrap), 64'd3);
    check("degen.group", 64'(out_group), 64'd3);
    out_ready = 1'b1;
    tick();
    check("degen.done", 64'(done), 64'd1);
    tick();

    // Address wrap modulo 2^24
    cfg_loop_w(2, 1, 1, 2);
    cfg_base_w(2, 24'hFFFFFF);
    do_start(2);
    check("awrap.addr0", 64'(out_addr), 64'hFFFFFF);
    check("awrap.wrap0", 64'(wrap), 64'd0);
    check("awrap.last0", 64'(out_last), 64'd0);
    tick();
    check("awrap.addr1", 64'(out_addr), 64'd1);
    check("awrap.last1", 64'(out_last), 64'd1);
    check("awrap.wrap1", 64'(wrap), 64'd3);
    tick();
    check("awrap.done", 64'(done), 64'd1);
    tick();
    out_ready = 1'b0;

    // Preempt and resume
    cfg_base_w(1, 500);
    do_start(0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    group_sel = 2'd1;
    check("pre.addr_before_switch", 64'(out_addr), 64'd102);
    tick();
    check("pre.switch_out_v", 64'(out_v), 64'd0);
    check("pre.switch_busy", 64'(busy), 64'd1);
    tick();
    check("pre.idle_busy", 64'(busy), 64'd0);
    check("pre.idle_group", 64'(out_group), 64'd1);
    do_start(1);
    check("pre.g1_addr", 64'(out_addr), 64'd500);
    check("pre.g1_last", 64'(out_last), 64'd1);
    check("pre.g1_group", 64'(out_group), 64'd1);
    out_ready = 1'b1;
    tick();
    check("pre.g1_done", 64'(done), 64'd1);
    out_ready = 1'b0;
    group_sel = 2'd0;
    tick();
    check("pre.idle2_busy", 64'(busy), 64'd0);
    tick();
    check("pre.resume_switch_busy", 64'(busy), 64'd1);
    check("pre.resume_switch_v", 64'(out_v), 64'd0);
    tick();
    check("pre.resume_v", 64'(out_v), 64'd1);
    check("pre.resume_addr", 64'(out_addr), 64'd102);
    check("pre.resume_iter1", 64'(out_iters[2*IW-1:IW]), 64'd2);
    check("pre.resume_group", 64'(out_group), 64'd0);
    collect(-1, nb, last_a);
    check("pre.resume_beats", 64'(nb), 64'd4);
    check("pre.resume_last_addr", 64'(last_a), 64'd112);

    // Config shadowing
    do_start(0);
    collect(1, nb, last_a);
    check("shadow.cur_beats", 64'(nb), 64'd6);
    check("shadow.cur_last_addr", 64'(last_a), 64'd112);
    do_start(0);
    collect(-1, nb, last_a);
    check("shadow.next_beats", 64'(nb), 64'd12);
    check("shadow.next_last_addr", 64'(last_a), 64'd115);
    out_ready = 1'b0;

    // Reset mid-run, with g1 left ACTIVE beforehand
    cfg_loop_w(1, 1, 1, 1);
    do_start(1);
    check("rmid.g1_addr", 64'(out_addr), 64'd500);
    group_sel = 2'd0;
    tick();
    tick();
    check("rmid.idle_busy", 64'(busy), 64'd0);
    do_start(0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    check("rmid.addr_after_3", 64'(out_addr), 64'd103);
    reset = 1'b1;
    tick();
    check("rmid.out_v", 64'(out_v), 64'd0);
    check("rmid.busy", 64'(busy), 64'd0);
    check("rmid.done", 64'(done), 64'd0);
    check("rmid.addr", 64'(out_addr), 64'd0);
    check("rmid.iters", 64'(out_iters), 64'd0);
    check("rmid.group", 64'(out_group), 64'd0);
    reset = 1'b0;
    group_sel = 2'd1;
    tick();
    tick();
    tick();
    check("rmid.g1_not_resumed", 64'(busy), 64'd0);
    do_start(0);
    check("rmid.cleared_v", 64'(out_v), 64'd1);
    check("rmid.cleared_addr", 64'(out_addr), 64'd0);
    check("rmid.cleared_last", 64'(out_last), 64'd1);
    out_ready = 1'b1;
    tick();
    check("rmid.cleared_done", 64'(done), 64'd1);
    tick();
    check("rmid.final_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
